// File: rtl/host_slave_switch_ctrl.sv
// Host/slave role sequencer for the shared USB SIE: drain, soft-reset, flip hostMode, settle.
// Build option: define HOST_SLAVE_SWITCH_TIMEOUT_EN to bound the DRAIN dwell by IDLE_TIMEOUT.
//   state    | meaning
//   S_IDLE   | role stable, waiting for modeReq to differ from hostMode
//   S_DRAIN  | port writes blocked, waiting for two consecutive SIE idle cycles
//   S_RESET  | SIE soft reset held for RST_CYCLES
//   S_SETTLE | new role applied, line quiet for SETTLE_CYCLES
module host_slave_switch_ctrl #(
  parameter int unsigned RST_CYCLES    = 16,
  parameter int unsigned SETTLE_CYCLES = 8,
  parameter int unsigned IDLE_TIMEOUT  = 255,
  parameter bit          DEFAULT_MODE  = 1'b0
) (
  input  logic usbClk,
  input  logic rstn,
  input  logic modeReq,
  input  logic sieBusy,
  output logic hostMode,
  output logic sieRst,
  output logic portWEnBlock,
  output logic busy,
  output logic switchDone,
  output logic switchTimeout
);

  typedef enum logic [1:0] {S_IDLE, S_DRAIN, S_RESET, S_SETTLE} state_e;

  localparam logic [7:0] RST_LAST    = 8'(RST_CYCLES - 1);
  localparam logic [7:0] SETTLE_LAST = 8'(SETTLE_CYCLES - 1);
  localparam logic [7:0] TOUT_LAST   = 8'(IDLE_TIMEOUT - 1);

  state_e     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic       idle_q, idle_d;
  logic       host_mode_q, host_mode_d;
  logic       done_d, tout_d;
  logic       sie_rst_q, block_q, done_q, tout_q;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    idle_d      = 1'b0;
    host_mode_d = host_mode_q;
    done_d      = 1'b0;
    tout_d      = 1'b0;
    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (modeReq != host_mode_q) state_d = S_DRAIN;
      end
      S_DRAIN: begin
        idle_d = ~sieBusy;
`ifdef HOST_SLAVE_SWITCH_TIMEOUT_EN
        cnt_d  = cnt_q + 8'd1;
`else
        // dwell count parks instead of wrapping; nothing consumes it in this build
        cnt_d  = (cnt_q == TOUT_LAST) ? cnt_q : cnt_q + 8'd1;
`endif
        if (modeReq == host_mode_q) begin
          state_d = S_IDLE;
          cnt_d   = '0;
          idle_d  = 1'b0;
        end else if (!sieBusy && idle_q) begin
          state_d = S_RESET;
          cnt_d   = '0;
          idle_d  = 1'b0;
`ifdef HOST_SLAVE_SWITCH_TIMEOUT_EN
        end else if (cnt_q == TOUT_LAST) begin
          state_d = S_RESET;
          cnt_d   = '0;
          idle_d  = 1'b0;
          tout_d  = 1'b1;
`endif
        end
      end
      S_RESET: begin
        if (cnt_q == RST_LAST) begin
          state_d     = S_SETTLE;
          cnt_d       = '0;
          host_mode_d = ~host_mode_q;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      S_SETTLE: begin
        if (cnt_q == SETTLE_LAST) begin
          state_d = S_IDLE;
          cnt_d   = '0;
          done_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Outputs are decoded from the next state so they line up with the state register.
  always_ff @(posedge usbClk) begin
    if (!rstn) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      idle_q      <= 1'b0;
      host_mode_q <= DEFAULT_MODE;
      sie_rst_q   <= 1'b0;
      block_q     <= 1'b0;
      done_q      <= 1'b0;
      tout_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      idle_q      <= idle_d;
      host_mode_q <= host_mode_d;
      sie_rst_q   <= (state_d == S_RESET);
      block_q     <= (state_d != S_IDLE);
      done_q      <= done_d;
      tout_q      <= tout_d;
    end
  end

  assign hostMode      = host_mode_q;
  assign sieRst        = sie_rst_q;
  assign portWEnBlock  = block_q;
  assign busy          = block_q;
  assign switchDone    = done_q;
  assign switchTimeout = tout_q;

endmodule

// File: tb/tb_host_slave_switch_ctrl.sv
// Scoreboard bench for host_slave_switch_ctrl: expected output snapshots are queued per edge.
module tb_host_slave_switch_ctrl;

  localparam logic [5:0] M_HM   = 6'b100000;
  localparam logic [5:0] M_RST  = 6'b010000;
  localparam logic [5:0] M_BLK  = 6'b001000;
  localparam logic [5:0] M_BSY  = 6'b000100;
  localparam logic [5:0] M_DONE = 6'b000010;
  localparam logic [5:0] M_TO   = 6'b000001;
  localparam logic [5:0] M_ALL  = 6'b111111;
  localparam logic [5:0] ZERO   = 6'b000000;

  logic usbClk = 1'b0;
  logic rstn, modeReq, sieBusy;
  logic hostMode, sieRst, portWEnBlock, busy, switchDone, switchTimeout;
  logic [5:0] outv;

  int cyc   = 0;
  int total = 0;
  int bad   = 0;
  int k, f;

  typedef struct {
    int         at;
    logic [5:0] mask;
    logic [5:0] val;
    string      tag;
  } exp_t;
  exp_t sb[$];

  host_slave_switch_ctrl #(
    .RST_CYCLES   (16),
    .SETTLE_CYCLES(8),
    .IDLE_TIMEOUT (50),
    .DEFAULT_MODE (1'b0)
  ) dut (
    .usbClk       (usbClk),
    .rstn         (rstn),
    .modeReq      (modeReq),
    .sieBusy      (sieBusy),
    .hostMode     (hostMode),
    .sieRst       (sieRst),
    .portWEnBlock (portWEnBlock),
    .busy         (busy),
    .switchDone   (switchDone),
    .switchTimeout(switchTimeout)
  );

  always #5 usbClk = ~usbClk;
  always @(posedge usbClk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %b want %b (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic push(input int at, input logic [5:0] mask, input logic [5:0] val, input string tag);
    sb.push_back('{at, mask, val, tag});
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge usbClk);
  endtask

  // Output vector: {hostMode, sieRst, portWEnBlock, busy, switchDone, switchTimeout}
  always @(negedge usbClk) begin
    outv = {hostMode, sieRst, portWEnBlock, busy, switchDone, switchTimeout};
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].at == cyc) begin
        chk(sb[i].tag, 32'(outv & sb[i].mask), 32'(sb[i].val & sb[i].mask));
        sb.delete(i);
      end
    end
  end

  initial begin
    rstn = 1'b0; modeReq = 1'b0; sieBusy = 1'b0;
    tick(2);
    push(cyc + 1, M_ALL, ZERO, "rst_hold");
    push(cyc + 3, M_ALL, ZERO, "rst_idle");
    tick(1);
    rstn = 1'b1;
    tick(3);

    // A: clean switch to host
    k = cyc + 1;
    modeReq = 1'b1;
    push(k,      M_HM | M_RST | M_BLK | M_BSY, M_BLK | M_BSY, "A_drain");
    push(k + 1,  M_RST | M_BLK, M_BLK, "A_idle_cnt");
    push(k + 2,  M_HM | M_RST | M_BLK, M_RST | M_BLK, "A_reset_on");
    push(k + 17, M_HM | M_RST | M_DONE, M_RST, "A_reset_last");
    push(k + 18, M_HM | M_RST | M_BLK, M_HM | M_BLK, "A_flip");
    push(k + 25, M_HM | M_BLK | M_DONE, M_HM | M_BLK, "A_settle_last");
    push(k + 26, M_ALL, M_HM | M_DONE, "A_done");
    push(k + 27, M_ALL, M_HM, "A_done_end");
    tick(30);

    // B: SIE busy for 40 cycles, then switch back to slave
    k = cyc + 1;
    modeReq = 1'b0; sieBusy = 1'b1;
    push(k,      M_HM | M_BLK | M_BSY, M_HM | M_BLK | M_BSY, "B_drain");
    push(k + 20, M_RST | M_BLK | M_TO, M_BLK, "B_wait20");
    push(k + 39, M_HM | M_RST | M_BLK | M_TO, M_HM | M_BLK, "B_wait39");
    tick(40);
    sieBusy = 1'b0;
    f = cyc + 1;
    push(f,      M_RST | M_BLK, M_BLK, "B_idle_seen");
    push(f + 1,  M_HM | M_RST | M_TO, M_HM | M_RST, "B_reset_on");
    push(f + 17, M_HM | M_RST, ZERO, "B_flip");
    push(f + 25, M_HM | M_BLK | M_DONE | M_TO, M_DONE, "B_done");
    tick(28);

    // D: request cancelled one edge later
    k = cyc + 1;
    modeReq = 1'b1; sieBusy = 1'b1;
    push(k, M_RST | M_BLK | M_BSY, M_BLK | M_BSY, "D_drain");
    tick(1);
    modeReq = 1'b0;
    push(k + 1,  M_ALL, ZERO, "D_cancel");
    push(k + 5,  M_ALL, ZERO, "D_quiet5");
    push(k + 30, M_ALL, ZERO, "D_quiet30");
    tick(31);
    sieBusy = 1'b0;
    tick(2);

    // C: SIE stuck busy
    k = cyc + 1;
    modeReq = 1'b1; sieBusy = 1'b1;
`ifdef HOST_SLAVE_SWITCH_TIMEOUT_EN
    push(k + 49, M_TO | M_RST | M_BLK, M_BLK, "C_pre_tout");
    push(k + 50, M_HM | M_TO | M_RST, M_TO | M_RST, "C_tout");
    push(k + 51, M_TO | M_RST, M_RST, "C_tout_end");
    push(k + 66, M_HM | M_RST, M_HM, "C_flip");
    push(k + 74, M_HM | M_BLK | M_DONE, M_HM | M_DONE, "C_done");
    tick(76);
    sieBusy = 1'b0;
`else
    push(k + 50,  M_ALL, M_BLK | M_BSY, "C_drain50");
    push(k + 500, M_ALL, M_BLK | M_BSY, "C_drain500");
    push(k + 999, M_ALL, M_BLK | M_BSY, "C_drain999");
    tick(1000);
    sieBusy = 1'b0;
    f = cyc + 1;
    push(f + 1,  M_RST | M_TO, M_RST, "C_reset_on");
    push(f + 17, M_HM | M_RST, M_HM, "C_flip");
    push(f + 25, M_HM | M_DONE | M_BLK, M_HM | M_DONE, "C_done");
    tick(28);
`endif

    // E: request toggles back during SETTLE, causing a reverse switch
    k = cyc + 1;
    modeReq = 1'b0; sieBusy = 1'b0;
    push(k + 2,  M_HM | M_RST, M_HM | M_RST, "E_reset_on");
    push(k + 18, M_HM | M_RST, ZERO, "E_flip");
    push(k + 26, M_HM | M_BLK | M_BSY | M_DONE, M_DONE, "E_done1");
    push(k + 27, M_HM | M_BLK | M_BSY | M_DONE, M_BLK | M_BSY, "E_restart");
    push(k + 29, M_HM | M_RST, M_RST, "E_reset2_on");
    push(k + 45, M_HM | M_RST, M_HM, "E_flip2");
    push(k + 53, M_HM | M_BLK | M_DONE, M_HM | M_DONE, "E_done2");
    tick(21);
    modeReq = 1'b1;
    tick(36);

    // F1: reset during RESET with hostMode = 1 falls back to default
    k = cyc + 1;
    modeReq = 1'b0;
    push(k + 6, M_HM | M_RST | M_BLK, M_HM | M_RST | M_BLK, "F1_in_reset");
    tick(7);
    rstn = 1'b0;
    push(k + 7, M_ALL, ZERO, "F1_abort");
    tick(1);
    rstn = 1'b1;
    push(k + 10, M_ALL, ZERO, "F1_idle");
    push(k + 20, M_ALL, ZERO, "F1_no_flip");
    tick(22);

    // F2: reset during RESET with hostMode = 0 leaves it at 0
    k = cyc + 1;
    modeReq = 1'b1;
    push(k + 6, M_HM | M_RST | M_BLK, M_RST | M_BLK, "F2_in_reset");
    tick(7);
    rstn = 1'b0; modeReq = 1'b0;
    push(k + 7, M_ALL, ZERO, "F2_abort");
    tick(1);
    rstn = 1'b1;
    push(k + 20, M_ALL, ZERO, "F2_no_flip");
    tick(22);

    #1;
    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
